// File: rtl/mips_seq_pkg.sv
// -----------------------------------------------------------------------------
// Package: mips_seq_pkg
// Shared definitions for the MIPS multi-cycle instruction sequencer.
//   INSTR_W      instruction word width
//   OP_*         primary opcode values (instr[31:26]) understood by the sequencer
//   state_t      sequencer phase encoding
//   opcode_legal returns 1 for opcodes the sequencer retires
// Configuration macro: MIPS_SEQ_BRANCH_EN (when defined, OP_BEQ is legal).
// -----------------------------------------------------------------------------
package mips_seq_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'd0;
  localparam opcode_t OP_BEQ   = 6'd4;
  localparam opcode_t OP_LW    = 6'd35;
  localparam opcode_t OP_SW    = 6'd43;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_NEXT
  } state_t;

  // Opcodes that count towards the retired-instruction counter.
  function automatic logic opcode_legal(input opcode_t op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW: legal = 1'b1;
`ifdef MIPS_SEQ_BRANCH_EN
      OP_BEQ:                 legal = 1'b1;
`endif
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mips_pc_next.sv
// -----------------------------------------------------------------------------
// Module: mips_pc_next
// Combinational next-PC computation for the instruction sequencer.
//   pc          current PC (byte address, word aligned)
//   imm         16-bit branch immediate (word offset, signed)
//   take_branch 1 = branch target, 0 = sequential PC
//   pc_next     pc+4, or pc+4+(sext(imm)<<2); both wrap modulo 2^PC_W
// PC_W must be at least 19 so the sign extension has room.
// -----------------------------------------------------------------------------
module mips_pc_next #(
  parameter int unsigned PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic            take_branch,
  output logic [PC_W-1:0] pc_next
);

  localparam int EXT_W = PC_W - 18;

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] offset;

  assign seq_pc  = pc + PC_W'(4);
  // Immediate counts words: sign-extend, then scale to bytes.
  assign offset  = {{EXT_W{imm[15]}}, imm, 2'b00};
  assign pc_next = take_branch ? (seq_pc + offset) : seq_pc;

endmodule

// File: rtl/mips_instr_sequencer.sv
// -----------------------------------------------------------------------------
// Module: mips_instr_sequencer
// Multi-cycle instruction sequencer for the MIPS datapath. Owns the PC, fetches
// instruction words over a req/ack handshake, presents the latched word with a
// new_instr pulse and then fires single-cycle data-memory / register-file
// strobes in a fixed phase order per opcode:
//   R-type : FETCH DECODE EXEC WB NEXT           (reg_write in WB)
//   lw     : FETCH DECODE EXEC MEM WB NEXT       (mem_read in MEM, reg_write in WB)
//   sw     : FETCH DECODE EXEC MEM NEXT          (mem_write in MEM)
//   other  : FETCH DECODE EXEC NEXT              (illegal set, no strobes)
//
// Configuration macro: MIPS_SEQ_BRANCH_EN
//   defined   : beq (opcode 4) is legal, alu_zero is sampled in EXEC and NEXT
//               loads the branch target when it was set.
//   undefined : beq is treated as an illegal opcode and alu_zero is ignored.
//
// Ports:
//   clk, rst      clock (rising edge) / asynchronous active-high reset
//   run           level: keep sequencing; low parks in IDLE after current instr
//   imem_req      fetch request, held until imem_ack
//   imem_addr     fetch address (= pc)
//   imem_ack      fetch complete, imem_rdata valid in the same cycle
//   imem_rdata    fetched instruction word
//   instr         latched instruction word for the datapath
//   new_instr     one-cycle pulse after instr is updated
//   mem_read      data-memory read strobe
//   mem_write     data-memory write strobe
//   reg_write     register-file write strobe
//   alu_zero      ALU result is zero (branch build only)
//   pc            current PC
//   busy          high in every state except IDLE
//   illegal       sticky: unsupported opcode decoded
//   fetch_err     sticky: instruction fetch timed out
//   retired       count of legal instructions retired (wraps)
// -----------------------------------------------------------------------------
module mips_instr_sequencer
  import mips_seq_pkg::*;
#(
  parameter int unsigned     PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int unsigned     CNT_W         = 16,
  parameter int unsigned     FETCH_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               new_instr,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  input  logic               alu_zero,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               illegal,
  output logic               fetch_err,
  output logic [CNT_W-1:0]   retired
);

  // One spare bit so the counter never saturates below FETCH_TIMEOUT.
  localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 2);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              legal_q;   // current instruction counts as retired
  logic              take_branch;
  logic [PC_W-1:0]   pc_next;
  opcode_t           opcode;

  assign opcode    = instr[31:26];
  assign imem_addr = pc;

`ifdef MIPS_SEQ_BRANCH_EN
  logic taken_q;                // beq condition captured in EXEC
  assign take_branch = taken_q;
`else
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
  assign take_branch     = 1'b0;
`endif

  mips_pc_next #(
    .PC_W(PC_W)
  ) u_pc_next (
    .pc         (pc),
    .imm        (instr[15:0]),
    .take_branch(take_branch),
    .pc_next    (pc_next)
  );

  // NOTE: all sequencer state and outputs are updated with non-blocking
  // assignments so every register samples pre-edge values; blocking here
  // would make later statements see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      legal_q   <= 1'b0;
`ifdef MIPS_SEQ_BRANCH_EN
      taken_q   <= 1'b0;
`endif
      pc        <= RESET_PC;
      instr     <= '0;
      imem_req  <= 1'b0;
      new_instr <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      reg_write <= 1'b0;
      busy      <= 1'b0;
      illegal   <= 1'b0;
      fetch_err <= 1'b0;
      retired   <= '0;
    end else begin
      // Strobes are single-cycle pulses: cleared unless the transition below
      // raises one for the state being entered.
      new_instr <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      reg_write <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
          end
        end

        // run is deliberately not looked at here: a started fetch completes.
        ST_FETCH: begin
          if (imem_ack) begin
            instr     <= imem_rdata;
            imem_req  <= 1'b0;
            new_instr <= 1'b1;
            state     <= ST_DECODE;
          end else if (wait_cnt >= WAIT_W'(FETCH_TIMEOUT)) begin
            // Abort: PC stays on the failing address for diagnosis.
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_DECODE: begin
          legal_q <= opcode_legal(opcode);
`ifdef MIPS_SEQ_BRANCH_EN
          taken_q <= 1'b0;
`endif
          state   <= ST_EXEC;
        end

        // Operands / ALU settle during this cycle; the strobe of the next
        // phase is registered on the way out.
        ST_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              reg_write <= 1'b1;
              state     <= ST_WB;
            end
            OP_LW: begin
              mem_read <= 1'b1;
              state    <= ST_MEM;
            end
            OP_SW: begin
              mem_write <= 1'b1;
              state     <= ST_MEM;
            end
`ifdef MIPS_SEQ_BRANCH_EN
            OP_BEQ: begin
              taken_q <= alu_zero;
              state   <= ST_NEXT;
            end
`endif
            default: begin
              illegal <= 1'b1;
              state   <= ST_NEXT;
            end
          endcase
        end

        ST_MEM: begin
          if (opcode == OP_LW) begin
            reg_write <= 1'b1;
            state     <= ST_WB;
          end else begin
            state <= ST_NEXT;
          end
        end

        ST_WB: begin
          state <= ST_NEXT;
        end

        ST_NEXT: begin
          pc <= pc_next;
          if (legal_q) begin
            retired <= retired + CNT_W'(1);
          end
          if (run) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
